// File: rtl/booth_seq_multiplier_if.sv
// rtl/booth_seq_multiplier_if.sv - start/done handshake bundle for the sequential Booth multiplier
//
// Signals:
//   start      request an operation (honoured only while busy=0)
//   is_signed  1 = two's-complement operands, 0 = unsigned
//   a, b       N-bit multiplicand / multiplier, captured with start
//   busy       operation in progress
//   done       one-cycle pulse, product/overflow final
//   product    2N-bit result, held until the next accepted start
//   overflow   result does not fit in N bits for the selected mode
// Modports: master = datapath controller, slave = multiplier.
interface booth_seq_multiplier_if #(
    parameter int N = 32
);
    logic             start;
    logic             is_signed;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;
    logic             overflow;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, product, overflow
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, product, overflow
    );
endinterface

// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - sequential radix-4 Booth multiplier, one digit per clock
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    booth_seq_multiplier_if.slave (start, is_signed, a, b in; busy, done, product, overflow out)
// Operands are extended to N+2 bits so that unsigned values become positive
// signed values and one Booth recoding handles both modes. The accumulator
// holds {partial high, remaining multiplier} and shifts right two bits per digit.
module booth_seq_multiplier #(
    parameter int N = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    booth_seq_multiplier_if.slave  bus
);
    localparam int W    = N + 2;          // extended operand width
    localparam int AW   = 2 * W;          // accumulator width
    localparam int ITER = N / 2 + 1;      // Booth digits per operation
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] ITER_C = CW'(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    acc;
    logic             acc_q;              // bit to the right of the multiplier LSB
    logic [W+1:0]     mcand;              // multiplicand, wide enough to hold +-2M
    logic [CW-1:0]    cnt;
    logic             sgn;
    logic [2*N-1:0]   product_r;
    logic             overflow_r;

    logic             accept;
    logic             last;
    logic [W-1:0]     a_ext;
    logic [W-1:0]     b_ext;
    logic [2:0]       digit;
    logic [W+1:0]     pp;
    logic [W+1:0]     sum;
    logic [AW-1:0]    acc_shift;
    logic [2*N-1:0]   prod_fin;
    logic             ovf_fin;

    assign accept = bus.start && (state != RUN);
    assign last   = (state == RUN) && (cnt == ITER_C);

    assign a_ext = {{2{bus.is_signed & bus.a[N-1]}}, bus.a};
    assign b_ext = {{2{bus.is_signed & bus.b[N-1]}}, bus.b};

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; the DONE cycle may accept a new start directly
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (cnt == ITER_C) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Booth recoding of {b[2i+1], b[2i], b[2i-1]} and one shift step
    always_comb begin
        digit = {acc[1:0], acc_q};
        pp    = '0;
        case (digit)
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = -(mcand << 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
        // The sum is two bits wider than the high half; placing it at the
        // top of the shifted accumulator is exactly an arithmetic shift by 2.
        sum       = {{2{acc[AW-1]}}, acc[AW-1:W]} + pp;
        acc_shift = {sum, acc[W-1:2]};
    end

    always_comb begin
        prod_fin = acc[2*N-1:0];
        if (sgn) begin
            ovf_fin = !((&prod_fin[2*N-1:N-1]) || !(|prod_fin[2*N-1:N-1]));
        end else begin
            ovf_fin = |prod_fin[2*N-1:N];
        end
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            acc_q      <= 1'b0;
            mcand      <= '0;
            cnt        <= '0;
            sgn        <= 1'b0;
            product_r  <= '0;
            overflow_r <= 1'b0;
        end else if (accept) begin
            acc   <= {{W{1'b0}}, b_ext};
            acc_q <= 1'b0;
            mcand <= {{2{a_ext[W-1]}}, a_ext};
            cnt   <= '0;
            sgn   <= bus.is_signed;
        end else if (last) begin
            product_r  <= prod_fin;
            overflow_r <= ovf_fin;
        end else if (state == RUN) begin
            acc   <= acc_shift;
            acc_q <= acc[1];
            cnt   <= cnt + 1'b1;
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.product  = product_r;
    assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb/tb_booth_seq_multiplier.sv - self-checking bench for booth_seq_multiplier (N=32)
module tb_booth_seq_multiplier;
    localparam int N = 32;
    localparam int LAT = N / 2 + 2;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    booth_seq_multiplier_if #(.N(N)) bus ();

    booth_seq_multiplier #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint sa, sb;
        longint unsigned ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'h0, a};
        ub = {32'h0, b};
        return 64'(ua * ub);
    endfunction

    function automatic bit ref_ovf(input logic [63:0] p, input bit s);
        longint sp;
        if (s) begin
            sp = $signed(p);
            return (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
        end
        return p > 64'h00000000FFFFFFFF;
    endfunction

    // Drive a request just after a rising edge; the next edge samples it.
    task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input bit s);
        bus.start     = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.is_signed = s;
    endtask

    // Count edges after the sampling edge until done is seen; bounded.
    task automatic wait_done(output int lat);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.done) break;
        end
    endtask

    task automatic test_reset;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else pass_cnt++;
        total_cnt++; if (bus.product !== 64'h0) $display("FAIL reset_product got=%h exp=0", bus.product); else pass_cnt++;
        total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", bus.overflow); else pass_cnt++;
    endtask

    task automatic run_and_check(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input bit s, input logic [63:0] exp_p, input bit exp_o);
        int lat;
        drive_start(a, b, s);
        wait_done(lat);
        total_cnt++;
        if (lat !== LAT) $display("FAIL %s_latency got=%0d exp=%0d", name, lat, LAT); else pass_cnt++;
        total_cnt++;
        if (bus.product !== exp_p) $display("FAIL %s_product got=%h exp=%h", name, bus.product, exp_p); else pass_cnt++;
        total_cnt++;
        if (bus.overflow !== exp_o) $display("FAIL %s_overflow got=%b exp=%b", name, bus.overflow, exp_o); else pass_cnt++;
    endtask

    task automatic test_directed;
        run_and_check("sgn_big",  32'd211819911, 32'd12345, 1'b1, 64'd2614916801295, 1'b1);
        run_and_check("sgn_negneg", -32'sd2111, -32'sd552233, 1'b1, 64'd1165763863, 1'b0);
        run_and_check("sgn_posneg", 32'd502, -32'sd4, 1'b1, -64'sd2008, 1'b0);
        run_and_check("uns_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b1);
        run_and_check("sgn_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h1, 1'b0);
        run_and_check("sgn_minneg1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h0000000080000000, 1'b1);
        run_and_check("zero", 32'h0, 32'h0, 1'b1, 64'h0, 1'b0);
        run_and_check("uns_min", 32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000, 1'b1);
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        bit s;
        logic [63:0] p;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            if (i % 4 == 1) a = 32'($signed(16'($urandom)));
            if (i % 4 == 2) b = $urandom_range(0, 7);
            p = ref_mul(a, b, s);
            run_and_check("random", a, b, s, p, ref_ovf(p, s));
        end
    endtask

    task automatic test_busy_ignore;
        int lat;
        logic [63:0] prev, exp_p;
        bit stable_ok;
        prev  = bus.product;
        exp_p = ref_mul(32'd123456, -32'sd789, 1'b1);
        stable_ok = 1'b1;
        drive_start(32'd123456, -32'sd789, 1'b1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.done) break;
            if (bus.product !== prev) stable_ok = 1'b0;
            if (lat == 5) begin
                total_cnt++;
                if (bus.busy !== 1'b1) $display("FAIL busy_in_run got=%b exp=1", bus.busy); else pass_cnt++;
                drive_start(32'hDEADBEEF, 32'h12345678, 1'b0);
            end
            if (lat == 8) bus.start = 1'b0;
        end
        total_cnt++;
        if (!stable_ok) $display("FAIL product_stable_in_run got=changed exp=%h", prev); else pass_cnt++;
        total_cnt++;
        if (lat !== LAT) $display("FAIL ignore_latency got=%0d exp=%0d", lat, LAT); else pass_cnt++;
        total_cnt++;
        if (bus.product !== exp_p) $display("FAIL ignore_product got=%h exp=%h", bus.product, exp_p); else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL ignore_no_restart got=done%b/busy%b exp=0/0", bus.done, bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [63:0] p1, p2;
        p1 = ref_mul(32'd40000, 32'd70000, 1'b0);
        p2 = ref_mul(-32'sd3, 32'd1000001, 1'b1);
        drive_start(32'd40000, 32'd70000, 1'b0);
        wait_done(lat);
        total_cnt++;
        if (bus.product !== p1) $display("FAIL b2b_first got=%h exp=%h", bus.product, p1); else pass_cnt++;
        total_cnt++;
        if (bus.overflow !== 1'b0) $display("FAIL b2b_first_ovf got=%b exp=0", bus.overflow); else pass_cnt++;
        drive_start(-32'sd3, 32'd1000001, 1'b1);
        wait_done(lat);
        total_cnt++;
        if (lat !== LAT) $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT); else pass_cnt++;
        total_cnt++;
        if (bus.product !== p2) $display("FAIL b2b_second got=%h exp=%h", bus.product, p2); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic [63:0] p;
        drive_start(32'd99991, 32'd77773, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.done !== 1'b0) $display("FAIL midrst_done got=%b exp=0", bus.done); else pass_cnt++;
        total_cnt++; if (bus.product !== 64'h0) $display("FAIL midrst_product got=%h exp=0", bus.product); else pass_cnt++;
        total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL midrst_overflow got=%b exp=0", bus.overflow); else pass_cnt++;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        p = ref_mul(-32'sd65536, 32'd65536, 1'b1);
        run_and_check("after_rst", -32'sd65536, 32'd65536, 1'b1, p, ref_ovf(p, 1'b1));
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
